// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU block.
// Holds the R-type funct constants, the 4-bit internal control codes,
// the control FSM state type and the funct decoder.
package alu_pkg;

    localparam logic [5:0] FunctAdd  = 6'b100000;
    localparam logic [5:0] FunctSub  = 6'b100010;
    localparam logic [5:0] FunctMult = 6'b011000;
    localparam logic [5:0] FunctDiv  = 6'b011010;
    localparam logic [5:0] FunctSll  = 6'b000000;
    localparam logic [5:0] FunctSrl  = 6'b000010;
    localparam logic [5:0] FunctAnd  = 6'b100100;
    localparam logic [5:0] FunctOr   = 6'b100101;
    localparam logic [5:0] FunctXor  = 6'b100110;
    localparam logic [5:0] FunctNor  = 6'b100111;

    typedef enum logic [3:0] {
        CtrlAdd  = 4'b0000,
        CtrlSub  = 4'b0001,
        CtrlMult = 4'b0010,
        CtrlDiv  = 4'b0011,
        CtrlSll  = 4'b0100,
        CtrlSrl  = 4'b0101,
        CtrlAnd  = 4'b1000,
        CtrlOr   = 4'b1001,
        CtrlXor  = 4'b1010,
        CtrlNor  = 4'b1011
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      legal;
    } alu_dec_t;

    // Unsupported codes report legal=0; ctrl is then a harmless defined value.
    function automatic alu_dec_t funct_to_ctrl(input logic [5:0] funct);
        alu_dec_t dec;
        dec.ctrl  = CtrlAdd;
        dec.legal = 1'b1;
        case (funct)
            FunctAdd:  dec.ctrl = CtrlAdd;
            FunctSub:  dec.ctrl = CtrlSub;
            FunctMult: dec.ctrl = CtrlMult;
            FunctDiv:  dec.ctrl = CtrlDiv;
            FunctSll:  dec.ctrl = CtrlSll;
            FunctSrl:  dec.ctrl = CtrlSrl;
            FunctAnd:  dec.ctrl = CtrlAnd;
            FunctOr:   dec.ctrl = CtrlOr;
            FunctXor:  dec.ctrl = CtrlXor;
            FunctNor:  dec.ctrl = CtrlNor;
            default:   dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Issue/result bundle of the sequential ALU.
//   master (issuer): drives start, funct, op_a, op_b, shamt;
//                    observes busy, done, result, hi, lo, illegal.
//   slave  (ALU):    the reverse.
interface alu_seq_unit_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) ();

    logic               start;
    logic [5:0]         funct;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               illegal;

    modport master (
        output start, funct, op_a, op_b, shamt,
        input  busy, done, result, hi, lo, illegal
    );

    modport slave (
        input  start, funct, op_a, op_b, shamt,
        output busy, done, result, hi, lo, illegal
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
//   clk, reset : clock, async active-high reset
//   i_go       : load operands and perform the first iteration
//   i_is_div   : 1 = divide, 0 = multiply (captured with i_go)
//   i_a, i_b   : multiplier/multiplicand or dividend/divisor
//   o_fin      : one-cycle pulse once all WIDTH iterations are done
//   o_hi, o_lo : product {hi,lo} or remainder/quotient
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_go,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [CntW-1:0]  r_cnt;
    logic             r_run;
    logic             r_fin;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_hi_cur;
    logic [WIDTH-1:0] w_lo_cur;
    logic [WIDTH-1:0] w_b_cur;
    logic             w_div_cur;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // On i_go the step works on fresh operands (hi=0, lo=a), so the first
    // iteration overlaps the load cycle.
    always_comb begin
        w_hi_cur  = i_go ? '0 : r_hi;
        w_lo_cur  = i_go ? i_a : r_lo;
        w_b_cur   = i_go ? i_b : r_b;
        w_div_cur = i_go ? i_is_div : r_is_div;

        w_sum = {1'b0, w_hi_cur} + (w_lo_cur[0] ? {1'b0, w_b_cur} : '0);

        w_shl  = {w_hi_cur, w_lo_cur[WIDTH-1]};
        w_ge   = (w_shl >= {1'b0, w_b_cur});
        // When w_ge holds the difference is below the divisor, so WIDTH bits suffice.
        w_diff = w_shl[WIDTH-1:0] - w_b_cur;

        if (w_div_cur) begin
            w_hi_nxt = w_ge ? w_diff : w_shl[WIDTH-1:0];
            w_lo_nxt = {w_lo_cur[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], w_lo_cur[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_fin    <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else begin
            r_fin <= 1'b0;
            if (i_go) begin
                r_hi     <= w_hi_nxt;
                r_lo     <= w_lo_nxt;
                r_b      <= i_b;
                r_is_div <= i_is_div;
                r_cnt    <= CntW'(1);
                r_run    <= 1'b1;
            end else if (r_run) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + CntW'(1);
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    r_run <= 1'b0;
                    r_fin <= 1'b1;
                end
            end
        end
    end

    assign o_fin = r_fin;
    assign o_hi  = r_hi;
    assign o_lo  = r_lo;

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: decodes an R-type funct and runs it, single-cycle for
// logic/shift/add ops, iterative for MULT/DIV. Stalls the pipe via busy.
//   clk, reset : clock, async active-high reset
//   bus        : issue/result bundle (start, funct, op_a, op_b, shamt ->
//                busy, done, result, hi, lo, illegal)
// WIDTH must be a power of two and at least 8.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         reset,
    alu_seq_unit_if.slave bus
);

    alu_state_e       r_state;
    alu_state_e       w_state_d;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_illegal;

    alu_dec_t           w_dec;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_is_md;
    logic               w_is_div;
    logic               w_go;
    logic               w_load_sc;
    logic               w_load_dz;
    logic               w_load_md;
    logic               w_md_fin;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;

    assign w_dec    = funct_to_ctrl(bus.funct);
    assign w_shamt  = bus.shamt;
    assign w_is_div = w_dec.legal && (w_dec.ctrl == CtrlDiv);
    assign w_is_md  = w_dec.legal && ((w_dec.ctrl == CtrlMult) || (w_dec.ctrl == CtrlDiv));

    // Single-cycle datapath; illegal codes yield zero.
    always_comb begin
        w_sc_result = '0;
        if (w_dec.legal) begin
            case (w_dec.ctrl)
                CtrlAdd: w_sc_result = bus.op_a + bus.op_b;
                CtrlSub: w_sc_result = bus.op_a - bus.op_b;
                CtrlSll: w_sc_result = bus.op_b << w_shamt;
                CtrlSrl: w_sc_result = bus.op_b >> w_shamt;
                CtrlAnd: w_sc_result = bus.op_a & bus.op_b;
                CtrlOr:  w_sc_result = bus.op_a | bus.op_b;
                CtrlXor: w_sc_result = bus.op_a ^ bus.op_b;
                CtrlNor: w_sc_result = ~(bus.op_a | bus.op_b);
                default: w_sc_result = '0;
            endcase
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_go      = 1'b0;
        w_load_sc = 1'b0;
        w_load_dz = 1'b0;
        w_load_md = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (!w_is_md) begin
                        w_load_sc = 1'b1;
                        w_state_d = StDone;
                    end else if (w_is_div && (bus.op_b == '0)) begin
                        // Divide by zero resolves immediately, no iterations.
                        w_load_dz = 1'b1;
                        w_state_d = StDone;
                    end else begin
                        w_go      = 1'b1;
                        w_state_d = w_is_div ? StDiv : StMul;
                    end
                end
            end
            StMul, StDiv: begin
                if (w_md_fin) begin
                    w_load_md = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_result  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_load_sc) begin
                r_result  <= w_sc_result;
                r_illegal <= ~w_dec.legal;
            end
            if (w_load_dz) begin
                r_result  <= '1;
                r_lo      <= '1;
                r_hi      <= bus.op_a;
                r_illegal <= 1'b0;
            end
            if (w_load_md) begin
                r_result  <= w_md_lo;
                r_hi      <= w_md_hi;
                r_lo      <= w_md_lo;
                r_illegal <= 1'b0;
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_go     (w_go),
        .i_is_div (w_is_div),
        .i_a      (bus.op_a),
        .i_b      (bus.op_b),
        .o_fin    (w_md_fin),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    assign bus.busy    = (r_state != StIdle);
    assign bus.done    = (r_state == StDone);
    assign bus.result  = r_result;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit at WIDTH=32: fixed vector table,
// hand-written handshake/reset sequences, then random ops against a model.
module tb_alu_seq_unit;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    alu_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        int          lat;
    } vec_t;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: plain arithmetic on the architectural rules.
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] res, output logic ill,
                                  output int lat);
        logic [63:0] p;
        res = 32'd0;
        ill = 1'b0;
        lat = 1;
        case (f)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h18: begin
                p    = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                res  = p[31:0];
                lat  = WIDTH + 1;
            end
            6'h1A: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                    res  = 32'hFFFF_FFFF;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                    res  = a / b;
                    lat  = WIDTH + 1;
                end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Issues one op and returns the cycle of done (-1 on timeout). Inputs are
    // scrambled after the start edge to confirm operand capture.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output int lat);
        int nbusy;
        lat   = -1;
        nbusy = 0;
        @(negedge clk);
        check("idle_before_issue", {62'd0, bus.busy, bus.done}, 64'd0);
        bus.funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.shamt = sh;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        bus.shamt = 5'($urandom);
        bus.funct = 6'($urandom);
        for (int c = 1; c <= int'(WIDTH) + 8; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) $display("FAIL done_timeout: got no done expected done");
        check("busy_span", nbusy, lat);
    endtask

    vec_t        tbl [12];
    int          lat;
    int          ndone;
    int          first;
    logic [5:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rsh;
    logic [31:0] eres;
    logic        eill;
    int          elat;
    logic [5:0]  codes [11];

    initial begin
        checks   = 0;
        failures = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;

        tbl[0]  = '{6'h20, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         32'h0,         32'h0,         1'b0, 1};
        tbl[1]  = '{6'h22, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 32'h0,         32'h0,         1'b0, 1};
        tbl[2]  = '{6'h27, 32'h0F0F_0F0F, 32'h0,         5'd0,  32'hF0F0_F0F0, 32'h0,         32'h0,         1'b0, 1};
        tbl[3]  = '{6'h00, 32'h1234_5678, 32'h1,         5'd31, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1};
        tbl[4]  = '{6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h1,         32'hFFFF_FFFE, 32'h1,         1'b0, 33};
        tbl[5]  = '{6'h3F, 32'h1234,      32'h5678,      5'd3,  32'h0,         32'hFFFF_FFFE, 32'h1,         1'b1, 1};
        tbl[6]  = '{6'h1A, 32'd100,       32'd7,         5'd0,  32'd14,        32'd2,         32'd14,        1'b0, 33};
        tbl[7]  = '{6'h1A, 32'd9,         32'd0,         5'd0,  32'hFFFF_FFFF, 32'd9,         32'hFFFF_FFFF, 1'b0, 1};
        tbl[8]  = '{6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 32'd9,         32'hFFFF_FFFF, 1'b0, 1};
        tbl[9]  = '{6'h25, 32'hA000_0005, 32'h0A00_0050, 5'd0,  32'hAA00_0055, 32'd9,         32'hFFFF_FFFF, 1'b0, 1};
        tbl[10] = '{6'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 32'd9,         32'hFFFF_FFFF, 1'b0, 1};
        tbl[11] = '{6'h02, 32'hDEAD_BEEF, 32'h8000_0000, 5'd31, 32'h1,         32'd9,         32'hFFFF_FFFF, 1'b0, 1};

        codes = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h00, 6'h02, 6'h24, 6'h25, 6'h26, 6'h27, 6'h3F};

        bus.start = 1'b0;
        bus.funct = 6'd0;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        bus.shamt = 5'd0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_illegal", bus.illegal, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sh, lat);
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_result", i), bus.result, tbl[i].res);
            check($sformatf("tbl%0d_hi", i), bus.hi, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), bus.lo, tbl[i].lo);
            check($sformatf("tbl%0d_illegal", i), bus.illegal, tbl[i].ill);
        end

        // start pulsed (with new operands) while a MULT is in flight
        @(negedge clk);
        bus.funct = 6'h18;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        first = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.start = 1'b1;
                bus.funct = 6'h20;
                bus.op_a  = 32'd100;
                bus.op_b  = 32'd200;
            end
            if (c == 6) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_lat", first, 33);
        check("busy_start_result", bus.result, 15);
        check("busy_start_hi", bus.hi, 0);
        check("busy_start_lo", bus.lo, 15);

        // start held through the done cycle: accepted once the unit is idle
        @(negedge clk);
        bus.funct = 6'h20;
        bus.op_a  = 32'd1;
        bus.op_b  = 32'd2;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_done1", bus.done, 1);
        check("b2b_result1", bus.result, 3);
        bus.op_a = 32'd10;
        bus.op_b = 32'd20;
        @(negedge clk);
        check("b2b_gap", bus.done, 0);
        @(negedge clk);
        check("b2b_done2", bus.done, 1);
        check("b2b_result2", bus.result, 30);
        check("b2b_lo_kept", bus.lo, 15);
        bus.start = 1'b0;

        // reset in cycle 10 of a DIV
        @(negedge clk);
        @(negedge clk);
        bus.funct = 6'h1A;
        bus.op_a  = 32'd1000;
        bus.op_b  = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        reset = 1'b1;
        #1;
        check("midrst_result", bus.result, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_illegal", bus.illegal, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op(6'h20, 32'd7, 32'd8, 5'd0, lat);
        check("post_rst_lat", lat, 1);
        check("post_rst_result", bus.result, 15);
        check("post_rst_hi", bus.hi, 0);

        // random ops against the model
        for (int n = 0; n < 150; n++) begin
            rf  = codes[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) rf = 6'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            rsh = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            if ((rf == 6'h1A) && ($urandom_range(0, 5) == 0)) rb = 32'd0;
            model(rf, ra, rb, rsh, eres, eill, elat);
            run_op(rf, ra, rb, rsh, lat);
            check($sformatf("rnd%0d_f%0h_lat", n, rf), lat, elat);
            check($sformatf("rnd%0d_f%0h_result", n, rf), bus.result, eres);
            check($sformatf("rnd%0d_f%0h_hi", n, rf), bus.hi, m_hi);
            check($sformatf("rnd%0d_f%0h_lo", n, rf), bus.lo, m_lo);
            check($sformatf("rnd%0d_f%0h_illegal", n, rf), bus.illegal, eill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
